uart_fifo_wr: RTL and testbench

Write-side controller of the 256 x 8-bit UART FIFO path. Sits between the UART receiver and the FIFO write port: converts each received-byte strobe into exactly one FIFO write and absorbs short full periods in a small staging buffer. Holds off writes for a fixed interval after reset so the FIFO core finishes its own reset. Counts bytes lost to overflow.

---
 rtl/uart_fifo_wr.sv | 108 ++++++++++
 tb/tb_uart_fifo_wr.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_wr.sv
// Write-side controller for the UART FIFO: one FIFO write per rx_done rising edge, staged through short
// full periods, writes held off for INIT_WAIT cycles after reset, lost bytes counted.
module uart_fifo_wr #(
    parameter int DATA_W      = 8,
    parameter int STAGE_DEPTH = 4,
    parameter int INIT_WAIT   = 16,
    parameter int DROP_W      = 16
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         rx_done,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [DATA_W-1:0]            fifo_din,
    output logic                         ready,
    output logic [$clog2(STAGE_DEPTH):0] stage_cnt,
    output logic [DROP_W-1:0]            drop_cnt,
    output logic                         overflow
);
    localparam int AW = $clog2(STAGE_DEPTH);
    localparam int IW = $clog2(INIT_WAIT + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     init_cnt_q, init_cnt_d;
    logic              rx_d_q;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [STAGE_DEPTH];
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;
    logic              new_byte, push, pop, drop;

    assign stage_cnt = wr_ptr_q - rd_ptr_q;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;

        new_byte = rx_done & ~rx_d_q;
        pop      = (state_q == ST_RUN) & (stage_cnt != '0) & ~fifo_full;
        // A full stage still accepts a byte when an entry leaves on the same edge.
        push     = (state_q == ST_RUN) & new_byte &
                   ((stage_cnt < (AW+1)'(STAGE_DEPTH)) | pop);
        drop     = new_byte & ~push;

        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + IW'(1);
            if (init_cnt_q == IW'(INIT_WAIT - 1)) begin
                state_d = ST_RUN;
            end
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            rx_d_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rx_d_q     <= rx_done;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < STAGE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
        end
    end

    assign fifo_wr_en = pop;
    assign fifo_din   = mem_q[rd_ptr_q[AW-1:0]];
    assign ready      = (state_q == ST_RUN);
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_fifo_wr.sv
// Bench for uart_fifo_wr: scoreboard of expected FIFO writes plus a table of per-cycle staging vectors;
// a second small instance exercises drop counter saturation.
module tb_uart_fifo_wr;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done = 1'b1;
    logic [7:0] rx_data = '0;
    logic       fifo_full = 1'b0;
    logic       fifo_wr_en;
    logic [7:0] fifo_din;
    logic       ready;
    logic [2:0] stage_cnt;
    logic [15:0] drop_cnt;
    logic       overflow;

    logic       rst2 = 1'b1;
    logic       rx2_done = 1'b0;
    logic       fifo_wr_en2, ready2, overflow2;
    logic [7:0] fifo_din2;
    logic [2:0] stage_cnt2;
    logic [2:0] drop_cnt2;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic       rxd;
        logic [7:0] dat;
        logic       full;
        logic       sb_push;
        logic [2:0] stage;
        logic       wr;
        logic [15:0] drop;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    uart_fifo_wr #(.DATA_W(8), .STAGE_DEPTH(4), .INIT_WAIT(16), .DROP_W(16)) dut (
        .sys_clk(clk), .sys_rst(rst), .rx_done(rx_done), .rx_data(rx_data),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .ready(ready), .stage_cnt(stage_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    uart_fifo_wr #(.DATA_W(8), .STAGE_DEPTH(4), .INIT_WAIT(40), .DROP_W(3)) dut_sat (
        .sys_clk(clk), .sys_rst(rst2), .rx_done(rx2_done), .rx_data(8'h77),
        .fifo_full(1'b0), .fifo_wr_en(fifo_wr_en2), .fifo_din(fifo_din2),
        .ready(ready2), .stage_cnt(stage_cnt2), .drop_cnt(drop_cnt2), .overflow(overflow2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every FIFO write must match the oldest outstanding expected byte.
    always @(negedge clk) begin
        #2;
        if (fifo_wr_en === 1'b1) begin
            n_writes++;
            if (sb.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                check("sb_din", {24'd0, fifo_din}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic expect_wr);
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = d;
        if (expect_wr) sb.push_back(d);
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    function automatic void add(input logic rxd, input logic [7:0] dat, input logic full,
                                input logic sbp, input logic [2:0] stage, input logic wr,
                                input logic [15:0] drop);
        vec_t v;
        v.rxd = rxd; v.dat = dat; v.full = full; v.sb_push = sbp;
        v.stage = stage; v.wr = wr; v.drop = drop;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [7:0] bytes3 [3];
        int exp_drop;
        int w0;

        // Overflow staging: fill under full, drop two, then drain; then push+pop on a full stage.
        add(1, 8'hA0, 1, 1, 0, 0, 7);  add(0, 8'h00, 1, 0, 1, 0, 7);
        add(1, 8'hA1, 1, 1, 1, 0, 7);  add(0, 8'h00, 1, 0, 2, 0, 7);
        add(1, 8'hA2, 1, 1, 2, 0, 7);  add(0, 8'h00, 1, 0, 3, 0, 7);
        add(1, 8'hA3, 1, 1, 3, 0, 7);  add(0, 8'h00, 1, 0, 4, 0, 7);
        add(1, 8'hA4, 1, 0, 4, 0, 7);  add(0, 8'h00, 1, 0, 4, 0, 8);
        add(1, 8'hA5, 1, 0, 4, 0, 8);  add(0, 8'h00, 1, 0, 4, 0, 9);
        add(0, 8'h00, 0, 0, 4, 1, 9);  add(0, 8'h00, 0, 0, 3, 1, 9);
        add(0, 8'h00, 0, 0, 2, 1, 9);  add(0, 8'h00, 0, 0, 1, 1, 9);
        add(0, 8'h00, 0, 0, 0, 0, 9);
        add(1, 8'hB1, 1, 1, 0, 0, 9);  add(0, 8'h00, 1, 0, 1, 0, 9);
        add(1, 8'hB2, 1, 1, 1, 0, 9);  add(0, 8'h00, 1, 0, 2, 0, 9);
        add(1, 8'hB3, 1, 1, 2, 0, 9);  add(0, 8'h00, 1, 0, 3, 0, 9);
        add(1, 8'hB4, 1, 1, 3, 0, 9);  add(0, 8'h00, 1, 0, 4, 0, 9);
        add(1, 8'hB5, 0, 1, 4, 1, 9);  add(0, 8'h00, 0, 0, 4, 1, 9);
        add(0, 8'h00, 0, 0, 3, 1, 9);  add(0, 8'h00, 0, 0, 2, 1, 9);
        add(0, 8'h00, 0, 0, 1, 1, 9);  add(0, 8'h00, 0, 0, 0, 0, 9);

        // Reset values with rx_done held high through reset.
        repeat (3) @(negedge clk);
        #1;
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_din", fifo_din, 0);
        check("rst_ready", ready, 0);
        check("rst_stage", stage_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;

        // Init window: pulses at edges 3,5,..,15 are all dropped; ready rises at edge 16.
        exp_drop = 0;
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            if ((e % 2 == 1) && e >= 3 && e <= 15) exp_drop++;
            rx_done = ((e % 2 == 0) && e <= 14);
            #1;
            check("init_ready", ready, (e >= 16));
            check("init_drop", drop_cnt, exp_drop);
            check("init_ovf", overflow, (exp_drop > 0));
            check("init_wr_en", fifo_wr_en, 0);
        end

        // Isolated pulses: each written one edge after sampling, exactly one cycle.
        bytes3[0] = 8'h11; bytes3[1] = 8'h22; bytes3[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            send(bytes3[i], 1'b1);
            #1;
            check("lat_wr_en", fifo_wr_en, 1);
            check("lat_din", fifo_din, bytes3[i]);
            @(negedge clk);
            #1;
            check("single_wr", fifo_wr_en, 0);
            repeat (8) @(negedge clk);
        end
        check("pulses_drop", drop_cnt, 7);

        // Level held high: one write only.
        w0 = n_writes;
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = 8'h5C;
        sb.push_back(8'h5C);
        repeat (50) @(negedge clk);
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("level_writes", n_writes - w0, 1);

        foreach (tbl[i]) begin
            @(negedge clk);
            rx_done   = tbl[i].rxd;
            rx_data   = tbl[i].dat;
            fifo_full = tbl[i].full;
            if (tbl[i].sb_push) sb.push_back(tbl[i].dat);
            #1;
            check("tbl_stage", stage_cnt, tbl[i].stage);
            check("tbl_wr_en", fifo_wr_en, tbl[i].wr);
            check("tbl_drop", drop_cnt, tbl[i].drop);
            check("tbl_ovf", overflow, 1);
        end

        // Reset with three bytes staged: they must never reach the FIFO.
        fifo_full = 1'b1;
        send(8'hC0, 1'b0);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        #1;
        check("pre_rst_stage", stage_cnt, 3);
        check("pre_rst_din", fifo_din, 8'hC0);
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", fifo_wr_en, 0);
        check("mid_rst_din", fifo_din, 0);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_stage", stage_cnt, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        fifo_full = 1'b0;
        w0 = n_writes;
        repeat (20) @(negedge clk);
        #3;
        check("post_rst_writes", n_writes - w0, 0);
        check("post_rst_ready", ready, 1);
        check("post_rst_stage", stage_cnt, 0);

        // Drop counter saturation on the narrow instance, during its init window.
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            rx2_done = 1'b1;
            @(negedge clk);
            rx2_done = 1'b0;
            #1;
            check("sat_drop", drop_cnt2, (i < 7) ? i : 7);
        end
        check("sat_ovf", overflow2, 1);
        check("sat_ready", ready2, 0);
        check("sat_wr_en", fifo_wr_en2, 0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
